alu_issue_stage: RTL and testbench

- Registered ID/EX issue stage that drives the ALU's operand and control interface: inputs data1, data2 and the 4-bit ALU control code.
- Decodes a MIPS opcode/funct pair plus register-file operands into the ALU control code, applies operand selection and extension, and holds the result in a pipeline register.
- Sits between register-file read and the ALU; uses valid/ready handshakes on both sides, with flush.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/alu_issue_decode.sv | 104 ++++++++++
 rtl/alu_issue_stage.sv | 78 +++++++
 tb/tb_alu_issue_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode vocabulary: ALU control codes, opcode/funct values and the
// bundle handed from the issue stage to the ALU.
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLT  = 4'd9
  } alu_ctrl_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_ctrl_e       alu_control;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [4:0]      dest;
    logic            reg_write;
    logic            illegal;
  } issue_bundle_t;

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{(XLEN-16){imm[15]}}, imm};
  endfunction

  function automatic logic [XLEN-1:0] zero_ext16(input logic [15:0] imm);
    return {{(XLEN-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of opcode/funct plus register operands into the ALU
// issue bundle (control code, selected/extended operands, writeback target).
module alu_issue_decode
  import mips_pkg::*;
(
  input  logic [5:0]      in_opcode,
  input  logic [5:0]      in_funct,
  input  logic [4:0]      in_shamt,
  input  logic [4:0]      in_rt_idx,
  input  logic [4:0]      in_rd_idx,
  input  logic [15:0]     in_imm,
  input  logic [XLEN-1:0] in_rs_data,
  input  logic [XLEN-1:0] in_rt_data,
  output issue_bundle_t   out_bundle
);

  issue_bundle_t w_b;
  logic          w_legal;

  always_comb begin
    w_b     = '0;
    w_legal = 1'b1;
    if (in_opcode == OP_RTYPE) begin
      w_b.data1     = in_rs_data;
      w_b.data2     = in_rt_data;
      w_b.dest      = in_rd_idx;
      w_b.reg_write = 1'b1;
      case (in_funct)
        FN_ADD, FN_ADDU: w_b.alu_control = ALU_ADD;
        FN_SUB, FN_SUBU: w_b.alu_control = ALU_SUB;
        FN_AND:          w_b.alu_control = ALU_AND;
        FN_OR:           w_b.alu_control = ALU_OR;
        FN_NOR:          w_b.alu_control = ALU_NOR;
        FN_SLT:          w_b.alu_control = ALU_SLT;
        FN_SLTU:         w_b.alu_control = ALU_SLTU;
        // Shifts move rt into data1; the amount comes from shamt or rs[4:0]
        FN_SLL, FN_SRL: begin
          w_b.alu_control = (in_funct == FN_SLL) ? ALU_SLL : ALU_SRL;
          w_b.data1       = in_rt_data;
          w_b.data2       = {{(XLEN-5){1'b0}}, in_shamt};
        end
        FN_SLLV, FN_SRLV: begin
          w_b.alu_control = (in_funct == FN_SLLV) ? ALU_SLL : ALU_SRL;
          w_b.data1       = in_rt_data;
          w_b.data2       = {{(XLEN-5){1'b0}}, in_rs_data[4:0]};
        end
        default: w_legal = 1'b0;
      endcase
    end else begin
      w_b.data1     = in_rs_data;
      w_b.dest      = in_rt_idx;
      w_b.reg_write = 1'b1;
      case (in_opcode)
        OP_ADDI, OP_ADDIU, OP_LW: begin
          w_b.alu_control = ALU_ADD;
          w_b.data2       = sign_ext16(in_imm);
        end
        OP_SLTI: begin
          w_b.alu_control = ALU_SLT;
          w_b.data2       = sign_ext16(in_imm);
        end
        OP_SLTIU: begin
          w_b.alu_control = ALU_SLTU;
          w_b.data2       = sign_ext16(in_imm);
        end
        OP_ANDI: begin
          w_b.alu_control = ALU_AND;
          w_b.data2       = zero_ext16(in_imm);
        end
        OP_ORI: begin
          w_b.alu_control = ALU_OR;
          w_b.data2       = zero_ext16(in_imm);
        end
        // LUI is issued as imm << 16 so the ALU needs no dedicated op
        OP_LUI: begin
          w_b.alu_control = ALU_SLL;
          w_b.data1       = zero_ext16(in_imm);
          w_b.data2       = XLEN'(16);
        end
        OP_SW: begin
          w_b.alu_control = ALU_ADD;
          w_b.data2       = sign_ext16(in_imm);
          w_b.dest        = 5'd0;
          w_b.reg_write   = 1'b0;
        end
        OP_BEQ, OP_BNE: begin
          w_b.alu_control = ALU_SUB;
          w_b.data2       = in_rt_data;
          w_b.dest        = 5'd0;
          w_b.reg_write   = 1'b0;
        end
        default: w_legal = 1'b0;
      endcase
    end
    if (!w_legal) begin
      w_b         = '0;
      w_b.illegal = 1'b1;
    end
    if (w_b.dest == 5'd0) w_b.reg_write = 1'b0;
  end

  assign out_bundle = w_b;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the incoming instruction and holds the ALU bundle
// in a single-entry valid/ready pipeline register with flush.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter bit ILLEGAL_DROP = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [4:0]        in_rt_idx,
  input  logic [4:0]        in_rd_idx,
  input  logic [15:0]       in_imm,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_control,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [4:0]        out_dest,
  output logic              out_reg_write,
  output logic              out_illegal
);

  issue_bundle_t w_dec;
  issue_bundle_t r_bundle;
  logic          r_valid;
  logic          w_accept;
  logic          w_drop;

  alu_issue_decode u_decode (
    .in_opcode  (in_opcode),
    .in_funct   (in_funct),
    .in_shamt   (in_shamt),
    .in_rt_idx  (in_rt_idx),
    .in_rd_idx  (in_rd_idx),
    .in_imm     (in_imm),
    .in_rs_data (in_rs_data),
    .in_rt_data (in_rt_data),
    .out_bundle (w_dec)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_drop   = ILLEGAL_DROP && w_dec.illegal;

  // An accepted-but-dropped instruction only happens when the slot is empty or
  // draining this cycle, so clearing valid is correct in both cases.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= !w_drop;
      if (!w_drop) r_bundle <= w_dec;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid       = r_valid;
  assign out_alu_control = r_bundle.alu_control;
  assign out_data1       = r_bundle.data1;
  assign out_data2       = r_bundle.data2;
  assign out_dest        = r_bundle.dest;
  assign out_reg_write   = r_bundle.reg_write;
  assign out_illegal     = r_bundle.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases plus random traffic against a
// one-slot buffer model, run on both ILLEGAL_DROP settings side by side.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  dest;
    logic        wr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [4:0]  in_shamt, in_rt_idx, in_rd_idx;
  logic [15:0] in_imm;
  logic [31:0] in_rs_data, in_rt_data;

  logic        in_ready, out_valid, out_reg_write, out_illegal;
  logic [3:0]  out_alu_control;
  logic [31:0] out_data1, out_data2;
  logic [4:0]  out_dest;

  logic        d_in_ready, d_out_valid, d_out_reg_write, d_out_illegal;
  logic [3:0]  d_out_alu_control;
  logic [31:0] d_out_data1, d_out_data2;
  logic [4:0]  d_out_dest;

  int   n_cmp = 0;
  int   n_err = 0;
  logic m_valid [2];
  exp_t m_ent   [2];

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .ILLEGAL_DROP(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx), .in_imm(in_imm),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_control(out_alu_control),
    .out_data1(out_data1), .out_data2(out_data2), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  alu_issue_stage #(.DATA_W(32), .ILLEGAL_DROP(1'b1)) dut_drop (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx), .in_imm(in_imm),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .out_valid(d_out_valid), .out_ready(out_ready), .out_alu_control(d_out_alu_control),
    .out_data1(d_out_data1), .out_data2(d_out_data2), .out_dest(d_out_dest),
    .out_reg_write(d_out_reg_write), .out_illegal(d_out_illegal)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Instruction semantics straight from the ISA table.
  function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] sh, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm,
                                      input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] sx, zx;
    logic        ok;
    e  = '0;
    ok = 1'b1;
    sx = 32'($signed(imm));
    zx = {16'h0, imm};
    if (op == 6'h00) begin
      e.dest = rd; e.wr = 1'b1; e.d1 = a; e.d2 = b;
      case (fn)
        6'h20, 6'h21: e.ctl = 4'd1;
        6'h22, 6'h23: e.ctl = 4'd2;
        6'h24:        e.ctl = 4'd5;
        6'h25:        e.ctl = 4'd6;
        6'h27:        e.ctl = 4'd7;
        6'h2A:        e.ctl = 4'd9;
        6'h2B:        e.ctl = 4'd8;
        6'h00: begin e.ctl = 4'd3; e.d1 = b; e.d2 = 32'(sh); end
        6'h02: begin e.ctl = 4'd4; e.d1 = b; e.d2 = 32'(sh); end
        6'h04: begin e.ctl = 4'd3; e.d1 = b; e.d2 = 32'(a[4:0]); end
        6'h06: begin e.ctl = 4'd4; e.d1 = b; e.d2 = 32'(a[4:0]); end
        default: ok = 1'b0;
      endcase
    end else begin
      e.d1 = a; e.dest = rt; e.wr = 1'b1;
      case (op)
        6'h08, 6'h09, 6'h23: begin e.ctl = 4'd1; e.d2 = sx; end
        6'h0A: begin e.ctl = 4'd9; e.d2 = sx; end
        6'h0B: begin e.ctl = 4'd8; e.d2 = sx; end
        6'h0C: begin e.ctl = 4'd5; e.d2 = zx; end
        6'h0D: begin e.ctl = 4'd6; e.d2 = zx; end
        6'h0F: begin e.ctl = 4'd3; e.d1 = zx; e.d2 = 32'd16; end
        6'h2B: begin e.ctl = 4'd1; e.d2 = sx; e.dest = 5'd0; e.wr = 1'b0; end
        6'h04, 6'h05: begin e.ctl = 4'd2; e.d2 = b; e.dest = 5'd0; e.wr = 1'b0; end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      e     = '0;
      e.ill = 1'b1;
    end
    if (e.dest == 5'd0) e.wr = 1'b0;
    return e;
  endfunction

  // Inputs are set after a negedge; check ready, advance model, sample after the edge.
  task automatic tick();
    exp_t e;
    #1;
    check_eq("in_ready", in_ready, !m_valid[0] || out_ready);
    check_eq("in_ready_drop", d_in_ready, !m_valid[1] || out_ready);
    e = ref_decode(in_opcode, in_funct, in_shamt, in_rt_idx, in_rd_idx, in_imm,
                   in_rs_data, in_rt_data);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_valid[k] = 1'b0;
        m_ent[k]   = '0;
      end else if (flush) begin
        m_valid[k] = 1'b0;
      end else if (in_valid && (!m_valid[k] || out_ready)) begin
        if (k == 1 && e.ill) m_valid[k] = 1'b0;
        else begin
          m_valid[k] = 1'b1;
          m_ent[k]   = e;
        end
      end else if (out_ready) begin
        m_valid[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_eq("out_valid", out_valid, m_valid[0]);
    check_eq("bundle", {out_alu_control, out_data1, out_data2, out_dest, out_reg_write, out_illegal},
             m_ent[0]);
    check_eq("out_valid_drop", d_out_valid, m_valid[1]);
    if (m_valid[1])
      check_eq("bundle_drop", {d_out_alu_control, d_out_data1, d_out_data2, d_out_dest,
                               d_out_reg_write, d_out_illegal}, m_ent[1]);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                           input logic [31:0] a, input logic [31:0] b);
    in_opcode = op; in_funct = fn; in_shamt = sh; in_rt_idx = rt; in_rd_idx = rd;
    in_imm = imm; in_rs_data = a; in_rt_data = b;
  endtask

  logic [5:0] legal_ops [12] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                 6'h0D, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] legal_fns [13] = '{6'h00, 6'h02, 6'h04, 6'h06, 6'h20, 6'h21, 6'h22, 6'h23,
                                 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B};

  initial begin
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    m_ent[0] = '0; m_ent[1] = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_instr(6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0);
    @(negedge clk);
    tick();
    check_eq("reset_valid", out_valid, 1'b0);
    check_eq("reset_ctl", out_alu_control, 4'd0);
    rst = 1'b0;

    // ADD r3 = r? + r?
    in_valid = 1'b1; out_ready = 1'b1;
    set_instr(6'h00, 6'h20, 5'd0, 5'd7, 5'd3, 16'h1820, 32'd5, 32'd7);
    tick();
    check_eq("add_ctl", out_alu_control, 4'd1);
    check_eq("add_d1", out_data1, 32'd5);
    check_eq("add_d2", out_data2, 32'd7);
    check_eq("add_dest", out_dest, 5'd3);
    check_eq("add_wr", out_reg_write, 1'b1);
    check_eq("add_ill", out_illegal, 1'b0);

    set_instr(6'h00, 6'h00, 5'd4, 5'd1, 5'd2, 16'h1100, 32'hDEAD_BEEF, 32'd1);
    tick();
    check_eq("sll_ctl", out_alu_control, 4'd3);
    check_eq("sll_d1", out_data1, 32'd1);
    check_eq("sll_d2", out_data2, 32'd4);

    set_instr(6'h0F, 6'h0D, 5'd15, 5'd4, 5'd21, 16'hABCD, 32'h1234_5678, 32'h0);
    tick();
    check_eq("lui_ctl", out_alu_control, 4'd3);
    check_eq("lui_d1", out_data1, 32'h0000_ABCD);
    check_eq("lui_d2", out_data2, 32'd16);

    set_instr(6'h08, 6'h3F, 5'd31, 5'd6, 5'd31, 16'hFFFF, 32'd100, 32'h0);
    tick();
    check_eq("addi_d2", out_data2, 32'hFFFF_FFFF);
    set_instr(6'h0C, 6'h3F, 5'd31, 5'd6, 5'd31, 16'hFFFF, 32'd100, 32'h0);
    tick();
    check_eq("andi_d2", out_data2, 32'h0000_FFFF);
    set_instr(6'h04, 6'h01, 5'd0, 5'd8, 5'd0, 16'h0001, 32'd9, 32'd9);
    tick();
    check_eq("beq_ctl", out_alu_control, 4'd2);
    check_eq("beq_wr", out_reg_write, 1'b0);

    // Backpressure: beq stays put for two cycles
    out_ready = 1'b0;
    set_instr(6'h00, 6'h20, 5'd0, 5'd1, 5'd9, 16'h0, 32'd9, 32'd1);
    tick();
    tick();
    check_eq("stall_ctl", out_alu_control, 4'd2);
    check_eq("stall_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(6'h00, 6'h20, 5'd0, 5'd1, 5'd9, 16'h0, 32'(9 + i), 32'd1);
      tick();
      check_eq("b2b_valid", out_valid, 1'b1);
      check_eq("b2b_order", out_data1, 32'(9 + i));
    end

    // Flush with a held entry and a same-cycle input
    flush = 1'b1; out_ready = 1'b0;
    set_instr(6'h00, 6'h25, 5'd0, 5'd1, 5'd9, 16'h0, 32'h55, 32'd1);
    tick();
    check_eq("flush_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("flush_dropped", out_valid, 1'b0);

    in_valid = 1'b1; out_ready = 1'b1;
    set_instr(6'h3F, 6'h20, 5'd0, 5'd1, 5'd9, 16'h0, 32'h55, 32'd1);
    tick();
    check_eq("ill_flag", out_illegal, 1'b1);
    check_eq("ill_ctl", out_alu_control, 4'd0);
    check_eq("ill_drop_valid", d_out_valid, 1'b0);

    // Reset during a stall
    set_instr(6'h00, 6'h21, 5'd0, 5'd1, 5'd9, 16'h0, 32'h77, 32'd1);
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_eq("rst_all", {out_valid, out_alu_control, out_data1, out_data2, out_dest,
                         out_reg_write, out_illegal}, '0);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_opcode = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 1) == 0) in_opcode = 6'h00;
      in_funct   = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 12)];
      in_shamt   = 5'($urandom);
      in_rt_idx  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_rd_idx  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_imm     = 16'($urandom);
      in_rs_data = $urandom;
      in_rt_data = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
